// File: rtl/prototype_trainer.sv
// ============================================================================
// Module   : prototype_trainer
// Purpose  : Bundles labelled training hypervectors into four class prototypes
//            using saturating bipolar counters, then streams them out on finalize.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef HV_DIMENSION
`define HV_DIMENSION 64
`endif

module prototype_trainer #(
  parameter int DIMENSION = `HV_DIMENSION,
  parameter int CW        = 8,
  parameter int SCW       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hvin_valid,
  output logic                 hvin_ready,
  input  logic [DIMENSION-1:0] hvin,
  input  logic                 valence,
  input  logic                 arousal,
  input  logic                 finalize_valid,
  output logic                 finalize_ready,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic [1:0]           proto_id,
  output logic [DIMENSION-1:0] proto_hv,
  output logic [SCW-1:0]       sample_count
);

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] EMIT  = 1'b1;

  localparam logic [CW-1:0] c_acc_max = {1'b0, {(CW-1){1'b1}}};
  localparam logic [CW-1:0] c_acc_min = {1'b1, {(CW-1){1'b0}}};

  logic [0:0]    r_state;
  logic [CW-1:0] r_acc [4][DIMENSION];

  logic       w_hvin_fire;
  logic       w_final_fire;
  logic       w_dout_fire;
  logic       w_clear;
  logic [3:0] w_sel;

  // One bipolar step toward +1 or -1, clamped at the two's-complement extremes.
  function automatic logic [CW-1:0] sat_step(input logic [CW-1:0] a, input logic up);
    if (up) return (a == c_acc_max) ? a : a + 1'b1;
    else    return (a == c_acc_min) ? a : a - 1'b1;
  endfunction

  assign hvin_ready     = (r_state == ACCUM);
  assign finalize_ready = (r_state == ACCUM);
  assign w_hvin_fire    = hvin_valid && hvin_ready;
  assign w_final_fire   = finalize_valid && finalize_ready;
  assign w_dout_fire    = dout_valid && dout_ready;
  assign w_clear        = (r_state == EMIT) && w_dout_fire && (proto_id == 2'd3);

  // Class order matches proto_id: V_PLUS, V_MIN, A_HIGH, A_LOW.
  assign w_sel = {arousal, ~arousal, valence, ~valence};

  for (genvar c = 0; c < 4; c++) begin : g_class
    for (genvar b = 0; b < DIMENSION; b++) begin : g_bit
      always_ff @(posedge clk) begin
        if (rst || w_clear) begin
          r_acc[c][b] <= '0;
        end else if (w_hvin_fire && w_sel[c]) begin
          r_acc[c][b] <= sat_step(r_acc[c][b], hvin[b]);
        end
      end
    end
  end

  // Strictly positive counter -> 1; zero (tie) and negative -> 0.
  for (genvar b = 0; b < DIMENSION; b++) begin : g_out
    logic [CW-1:0] w_sel_acc;
    assign w_sel_acc   = r_acc[proto_id][b];
    assign proto_hv[b] = ~w_sel_acc[CW-1] && (|w_sel_acc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ACCUM;
      dout_valid   <= 1'b0;
      proto_id     <= 2'd0;
      sample_count <= '0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_hvin_fire && (sample_count != {SCW{1'b1}})) begin
            sample_count <= sample_count + 1'b1;
          end
          if (w_final_fire) begin
            r_state    <= EMIT;
            dout_valid <= 1'b1;
            proto_id   <= 2'd0;
          end
        end
        EMIT: begin
          if (w_dout_fire) begin
            if (proto_id == 2'd3) begin
              r_state      <= ACCUM;
              dout_valid   <= 1'b0;
              proto_id     <= 2'd0;
              sample_count <= '0;
            end else begin
              proto_id <= proto_id + 2'd1;
            end
          end
        end
        default: begin
          r_state    <= ACCUM;
          dout_valid <= 1'b0;
          proto_id   <= 2'd0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_prototype_trainer.sv
// ============================================================================
// Module   : tb_prototype_trainer
// Purpose  : Directed + randomized bench for prototype_trainer against an
//            integer-arithmetic class-counter model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_prototype_trainer;

  localparam int D   = 64;
  localparam int CW  = 8;
  localparam int SCW = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           hvin_valid = 1'b0;
  logic           hvin_ready;
  logic [D-1:0]   hvin = '0;
  logic           valence = 1'b0;
  logic           arousal = 1'b0;
  logic           finalize_valid = 1'b0;
  logic           finalize_ready;
  logic           dout_valid;
  logic           dout_ready = 1'b0;
  logic [1:0]     proto_id;
  logic [D-1:0]   proto_hv;
  logic [SCW-1:0] sample_count;

  int checks = 0;
  int errors = 0;

  int model [4][D];
  int mcount = 0;

  prototype_trainer #(.DIMENSION(D), .CW(CW), .SCW(SCW)) dut (
    .clk(clk), .rst(rst),
    .hvin_valid(hvin_valid), .hvin_ready(hvin_ready), .hvin(hvin),
    .valence(valence), .arousal(arousal),
    .finalize_valid(finalize_valid), .finalize_ready(finalize_ready),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .proto_id(proto_id), .proto_hv(proto_hv), .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [D-1:0] rand_hv();
    return {$urandom(), $urandom()};
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 4; c++)
      for (int b = 0; b < D; b++) model[c][b] = 0;
    mcount = 0;
  endtask

  task automatic model_add(input logic [D-1:0] hv, input logic v, input logic a);
    int cls [2];
    cls[0] = v ? 1 : 0;
    cls[1] = a ? 3 : 2;
    for (int k = 0; k < 2; k++)
      for (int b = 0; b < D; b++) begin
        model[cls[k]][b] += hv[b] ? 1 : -1;
        if (model[cls[k]][b] > 127)  model[cls[k]][b] = 127;
        if (model[cls[k]][b] < -128) model[cls[k]][b] = -128;
      end
    if (mcount < 65535) mcount++;
  endtask

  function automatic logic [D-1:0] expected_proto(input int c);
    logic [D-1:0] r;
    for (int b = 0; b < D; b++) r[b] = (model[c][b] > 0);
    return r;
  endfunction

  task automatic send(input logic [D-1:0] hv, input logic v, input logic a);
    hvin = hv; valence = v; arousal = a; hvin_valid = 1'b1;
    step();
    hvin_valid = 1'b0;
    model_add(hv, v, a);
  endtask

  task automatic do_finalize(input logic with_sample, input logic [D-1:0] hv,
                             input logic v, input logic a);
    finalize_valid = 1'b1;
    if (with_sample) begin
      hvin = hv; valence = v; arousal = a; hvin_valid = 1'b1;
    end
    step();
    finalize_valid = 1'b0;
    hvin_valid     = 1'b0;
    if (with_sample) model_add(hv, v, a);
  endtask

  // Drains all four beats; optionally stalls before firing beat stall_id.
  task automatic emit_all(input string name, input int stall_id, input int stall_cycles);
    for (int k = 0; k < 4; k++) begin
      if (k == stall_id) begin
        dout_ready = 1'b0;
        for (int s = 0; s < stall_cycles; s++) begin
          check($sformatf("%s_stall_valid", name), 64'(dout_valid), 64'(1));
          check($sformatf("%s_stall_id", name), 64'(proto_id), 64'(k));
          check($sformatf("%s_stall_hv", name), 64'(proto_hv), 64'(expected_proto(k)));
          check($sformatf("%s_stall_hvin_ready", name), 64'(hvin_ready), 64'(0));
          step();
        end
      end
      dout_ready = 1'b1;
      check($sformatf("%s_beat%0d_valid", name, k), 64'(dout_valid), 64'(1));
      check($sformatf("%s_beat%0d_id", name, k), 64'(proto_id), 64'(k));
      check($sformatf("%s_beat%0d_hv", name, k), 64'(proto_hv), 64'(expected_proto(k)));
      step();
    end
    dout_ready = 1'b0;
    model_clear();
    check($sformatf("%s_after_valid", name), 64'(dout_valid), 64'(0));
    check($sformatf("%s_after_count", name), 64'(sample_count), 64'(0));
    check($sformatf("%s_after_hvin_ready", name), 64'(hvin_ready), 64'(1));
  endtask

  initial begin
    logic [D-1:0] a_hv;
    logic [D-1:0] b_hv;
    logic [D-1:0] h;

    model_clear();
    step(); step();
    rst = 1'b0;
    check("reset_dout_valid", 64'(dout_valid), 64'(0));
    check("reset_proto_id", 64'(proto_id), 64'(0));
    check("reset_count", 64'(sample_count), 64'(0));
    check("reset_hvin_ready", 64'(hvin_ready), 64'(1));
    check("reset_finalize_ready", 64'(finalize_ready), 64'(1));

    // Empty finalize gives four all-zero prototypes.
    do_finalize(1'b0, '0, 1'b0, 1'b0);
    emit_all("empty", -1, 0);

    // Single sample on V_PLUS / A_LOW.
    a_hv = rand_hv();
    send(a_hv, 1'b0, 1'b1);
    check("single_count", 64'(sample_count), 64'(mcount));
    do_finalize(1'b0, '0, 1'b0, 1'b0);
    emit_all("single", -1, 0);

    // Majority over A, A, B on V_MIN / A_HIGH.
    a_hv = rand_hv();
    b_hv = rand_hv();
    send(a_hv, 1'b1, 1'b0);
    send(a_hv, 1'b1, 1'b0);
    send(b_hv, 1'b1, 1'b0);
    check("majority_count", 64'(sample_count), 64'(3));
    do_finalize(1'b0, '0, 1'b0, 1'b0);
    emit_all("majority", -1, 0);

    // Tie: A and ~A cancel to zero.
    a_hv = rand_hv();
    send(a_hv, 1'b0, 1'b0);
    send(~a_hv, 1'b0, 1'b0);
    do_finalize(1'b0, '0, 1'b0, 1'b0);
    emit_all("tie", -1, 0);

    // Saturation: 200 x bit0=1 then 150 x bit0=0 on V_PLUS.
    for (int i = 0; i < 200; i++) begin
      h = rand_hv(); h[0] = 1'b1;
      send(h, 1'b0, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 150; i++) begin
      h = rand_hv(); h[0] = 1'b0;
      send(h, 1'b0, 1'($urandom_range(0, 1)));
    end
    check("sat_count", 64'(sample_count), 64'(350));
    do_finalize(1'b0, '0, 1'b0, 1'b0);
    check("sat_bit0", 64'(proto_hv[0]), 64'(0));
    emit_all("sat", -1, 0);

    // Backpressure at id 2 for 5 cycles.
    for (int i = 0; i < 6; i++)
      send(rand_hv(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    do_finalize(1'b0, '0, 1'b0, 1'b0);
    emit_all("stall", 2, 5);

    // Sample and finalize in the same cycle.
    send(rand_hv(), 1'b1, 1'b1);
    do_finalize(1'b1, rand_hv(), 1'b1, 1'b1);
    emit_all("simul", -1, 0);

    // Random mixed training.
    for (int i = 0; i < 25; i++)
      send(rand_hv(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    check("random_count", 64'(sample_count), 64'(mcount));
    do_finalize(1'b0, '0, 1'b0, 1'b0);
    emit_all("random", -1, 0);

    // Reset after beat id=1.
    for (int i = 0; i < 4; i++)
      send(rand_hv(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    do_finalize(1'b0, '0, 1'b0, 1'b0);
    dout_ready = 1'b1;
    step();
    step();
    check("rst_pre_id", 64'(proto_id), 64'(2));
    dout_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_clear();
    check("rst_dout_valid", 64'(dout_valid), 64'(0));
    check("rst_count", 64'(sample_count), 64'(0));
    check("rst_hvin_ready", 64'(hvin_ready), 64'(1));
    check("rst_proto_id", 64'(proto_id), 64'(0));
    a_hv = rand_hv();
    send(a_hv, 1'b1, 1'b0);
    do_finalize(1'b0, '0, 1'b0, 1'b0);
    emit_all("post_rst", -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
